// File: rtl/uart_alu_intf.sv
// Frames three UART bytes (A, B, opcode) for an external ALU and hands its result to the UART TX.
// Optional inter-byte timeout enabled by defining UART_INTF_TIMEOUT_EN.
module uart_alu_intf #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned OP_W        = 6,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_rx_done,
    input  logic [7:0]        i_rx_byte,
    input  logic              i_tx_done,
    input  logic [DATA_W-1:0] i_alu_result,
    output logic [DATA_W-1:0] o_alu_a,
    output logic [DATA_W-1:0] o_alu_b,
    output logic [OP_W-1:0]   o_alu_op,
    output logic              o_tx_start,
    output logic [7:0]        o_tx_byte,
    output logic              o_busy,
    output logic              o_timeout
);

    typedef enum logic [2:0] {
        StWaitA,
        StWaitB,
        StWaitOp,
        StSend,
        StWaitTx
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [OP_W-1:0]   alu_op_q, alu_op_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic              tx_start_q, tx_start_d;
    logic              rx_done_q, tx_done_q;
    logic              rx_evt, tx_evt;
    logic              expire;

    // Rising-edge detect so a held done level advances the FSM only once.
    assign rx_evt = i_rx_done & ~rx_done_q;
    assign tx_evt = i_tx_done & ~tx_done_q;

`ifdef UART_INTF_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            partial;

    assign partial = (state_q == StWaitB) || (state_q == StWaitOp);
    // A byte arriving in the expiry cycle wins over the timeout.
    assign expire  = partial && !rx_evt && (cnt_q == CntW'(TIMEOUT_CYC - 1));

    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        if (rx_evt || expire || !partial) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        tx_byte_d  = tx_byte_q;
        tx_start_d = 1'b0;
        unique case (state_q)
            StWaitA: begin
                if (rx_evt) begin
                    alu_a_d = DATA_W'(i_rx_byte);
                    state_d = StWaitB;
                end
            end
            StWaitB: begin
                if (rx_evt) begin
                    alu_b_d = DATA_W'(i_rx_byte);
                    state_d = StWaitOp;
                end else if (expire) begin
                    state_d = StWaitA;
                end
            end
            StWaitOp: begin
                if (rx_evt) begin
                    alu_op_d = i_rx_byte[OP_W-1:0];
                    state_d  = StSend;
                end else if (expire) begin
                    state_d = StWaitA;
                end
            end
            StSend: begin
                // ALU result has had a full cycle to settle on the registered fields.
                tx_byte_d  = i_alu_result[7:0];
                tx_start_d = 1'b1;
                state_d    = StWaitTx;
            end
            StWaitTx: begin
                if (tx_evt) begin
                    state_d = StWaitA;
                end
            end
            default: state_d = StWaitA;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= StWaitA;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            tx_byte_q  <= '0;
            tx_start_q <= 1'b0;
            rx_done_q  <= 1'b1;
            tx_done_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            tx_byte_q  <= tx_byte_d;
            tx_start_q <= tx_start_d;
            rx_done_q  <= i_rx_done;
            tx_done_q  <= i_tx_done;
        end
    end

    assign o_alu_a    = alu_a_q;
    assign o_alu_b    = alu_b_q;
    assign o_alu_op   = alu_op_q;
    assign o_tx_byte  = tx_byte_q;
    assign o_tx_start = tx_start_q;
    assign o_busy     = (state_q == StSend) || (state_q == StWaitTx);
    assign o_timeout  = expire;

endmodule
